// File: rtl/icache_pkg.sv
// icache_pkg: shared types, widths and FSM encoding for the instruction cache.
package icache_pkg;
    localparam int ICACHE_INDEX_WIDTH = 6;
    localparam int ICACHE_ADDR_WIDTH  = 32;
    localparam int OFFSET_WIDTH       = 4;
    localparam int LINE_WIDTH         = 8 << OFFSET_WIDTH;
    localparam int WORD_SEL_WIDTH     = OFFSET_WIDTH - 2;

    typedef logic [31:0]               inst_t;
    typedef logic [LINE_WIDTH-1:0]     cache_line_t;
    typedef logic [WORD_SEL_WIDTH-1:0] word_sel_t;

    typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;

    // Byte k of a line sits at bits [8k+7:8k], so word w is a plain 32-bit slice.
    function automatic inst_t select_word(input cache_line_t line, input word_sel_t w);
        return line[32*w +: 32];
    endfunction
endpackage

// File: rtl/icache_line_array.sv
// icache_line_array: tag/valid/data storage, one async read port and one write port.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
    parameter int TAG_WIDTH   = ICACHE_ADDR_WIDTH - OFFSET_WIDTH - ICACHE_INDEX_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    output logic                   rd_valid,
    output logic [TAG_WIDTH-1:0]   rd_tag,
    output cache_line_t            rd_line,
    input  logic                   we,
    input  logic [INDEX_WIDTH-1:0] wr_index,
    input  logic [TAG_WIDTH-1:0]   wr_tag,
    input  cache_line_t            wr_line
);
    localparam int LINES = 1 << INDEX_WIDTH;

    logic [LINES-1:0]     valid;
    logic [TAG_WIDTH-1:0] tags  [LINES];
    cache_line_t          lines [LINES];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_line  = lines[rd_index];

    always_ff @(posedge clk) begin
        if (rst)
            valid <= '0;
        else if (we)
            valid[wr_index] <= 1'b1;
    end

    // Tags and data need no reset: they are only trusted behind a set valid bit.
    always_ff @(posedge clk) begin
        if (we) begin
            tags[wr_index]  <= wr_tag;
            lines[wr_index] <= wr_line;
        end
    end
endmodule

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache with line refill from mem_ctrler.
// Optional ICACHE_PERF_CNT_EN adds hit_cnt/miss_cnt ports.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
    parameter int ADDR_WIDTH  = ICACHE_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] addr_from_fetcher,
    input  logic                  valid_from_fetcher,
    output logic [31:0]           inst_to_fetcher,
    output logic                  ready_to_fetcher,
    output logic [ADDR_WIDTH-1:0] addr_to_mem,
    output logic                  valid_to_mem,
    input  cache_line_t           data_from_mem,
    input  logic                  ready_from_mem
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);
    localparam int TAG_WIDTH = ADDR_WIDTH - OFFSET_WIDTH - INDEX_WIDTH;

    state_t      state, state_n;
    word_sel_t   req_word, req_word_n;
    logic        killed, killed_n, ready_n, valid_mem_n;
    inst_t       inst_n;
    logic [ADDR_WIDTH-1:0] addr_mem_n;
    logic                  rd_valid, hit, accept, fill;
    logic [TAG_WIDTH-1:0]  rd_tag;
    cache_line_t           rd_line;
    logic                  unused;

    assign unused = ^addr_from_fetcher[1:0];
    assign hit    = rd_valid && rd_tag == addr_from_fetcher[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign accept = state == IDLE && valid_from_fetcher && !flush;
    assign fill   = state == MISS && ready_from_mem;

    // The held line address doubles as the fill index/tag, so only the word is latched.
    icache_line_array #(.INDEX_WIDTH(INDEX_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_lines (
        .clk      (clk),
        .rst      (rst),
        .rd_index (addr_from_fetcher[OFFSET_WIDTH +: INDEX_WIDTH]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .we       (rdy && fill),
        .wr_index (addr_to_mem[OFFSET_WIDTH +: INDEX_WIDTH]),
        .wr_tag   (addr_to_mem[ADDR_WIDTH-1 -: TAG_WIDTH]),
        .wr_line  (data_from_mem)
    );

    always_comb begin
        state_n     = state;
        req_word_n  = req_word;
        killed_n    = killed;
        ready_n     = 1'b0;
        valid_mem_n = valid_to_mem;
        inst_n      = inst_to_fetcher;
        addr_mem_n  = addr_to_mem;
        case (state)
            IDLE: if (accept) begin
                req_word_n = addr_from_fetcher[OFFSET_WIDTH-1:2];
                if (hit) begin
                    state_n = RESP;
                    ready_n = 1'b1;
                    inst_n  = select_word(rd_line, addr_from_fetcher[OFFSET_WIDTH-1:2]);
                end else begin
                    state_n     = MISS;
                    valid_mem_n = 1'b1;
                    addr_mem_n  = {addr_from_fetcher[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
                end
            end
            MISS: begin
                killed_n = killed || flush;
                if (ready_from_mem) begin
                    state_n     = RESP;
                    valid_mem_n = 1'b0;
                    ready_n     = !(killed || flush);
                    if (ready_n)
                        inst_n = select_word(data_from_mem, req_word);
                end
            end
            RESP: begin
                state_n  = IDLE;
                killed_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            req_word         <= '0;
            killed           <= 1'b0;
            ready_to_fetcher <= 1'b0;
            valid_to_mem     <= 1'b0;
            inst_to_fetcher  <= '0;
            addr_to_mem      <= '0;
        end else if (rdy) begin
            state            <= state_n;
            req_word         <= req_word_n;
            killed           <= killed_n;
            ready_to_fetcher <= ready_n;
            valid_to_mem     <= valid_mem_n;
            inst_to_fetcher  <= inst_n;
            addr_to_mem      <= addr_mem_n;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (rdy && accept) begin
            hit_cnt  <= hit_cnt + {31'd0, hit};
            miss_cnt <= miss_cnt + {31'd0, !hit};
        end
    end
`endif
endmodule

// File: tb/tb_icache.sv
// tb_icache: table vectors, corner-case sequences and randomized fetches against a line-level cache model.
module tb_icache;
    logic         clk = 1'b0, rst = 1'b1, rdy = 1'b1, flush = 1'b0;
    logic [31:0]  addr_from_fetcher = '0;
    logic         valid_from_fetcher = 1'b0;
    logic [31:0]  inst_to_fetcher;
    logic         ready_to_fetcher;
    logic [31:0]  addr_to_mem;
    logic         valid_to_mem;
    logic [127:0] data_from_mem = '0;
    logic         ready_from_mem = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt, miss_cnt;
`endif

    icache dut (
        .clk                (clk),
        .rst                (rst),
        .rdy                (rdy),
        .flush              (flush),
        .addr_from_fetcher  (addr_from_fetcher),
        .valid_from_fetcher (valid_from_fetcher),
        .inst_to_fetcher    (inst_to_fetcher),
        .ready_to_fetcher   (ready_to_fetcher),
        .addr_to_mem        (addr_to_mem),
        .valid_to_mem       (valid_to_mem),
        .data_from_mem      (data_from_mem),
        .ready_from_mem     (ready_from_mem)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_cnt            (hit_cnt),
        .miss_cnt           (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    // Model: which tag each of the 64 lines currently holds, plus accepted-request counts.
    bit          m_valid [64];
    logic [21:0] m_tag   [64];
    int          m_hits = 0, m_misses = 0;

    typedef struct {
        logic [31:0] addr;
        int          lat;
        bit          exp_hit;
    } vec_t;
    vec_t vt [6];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w == 32'h104) ? 32'hDEADBEEF : (w * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] la);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = mem_word(la + 32'(4*k));
        return l;
    endfunction

    // One full request from IDLE back to IDLE; kill redirects the fetcher during the miss.
    task automatic fetch(input logic [31:0] a, input int lat, input bit kill, input bit exp_hit, input string nm);
        logic [31:0] la;
        la = {a[31:4], 4'b0};
        addr_from_fetcher = a;
        valid_from_fetcher = 1'b1;
        step();
        if (exp_hit) begin
            m_hits++;
            check({nm, " hit ready"}, ready_to_fetcher, 1);
            check({nm, " hit inst"}, inst_to_fetcher, mem_word(a));
            check({nm, " hit vmem"}, valid_to_mem, 0);
        end else begin
            m_misses++;
            check({nm, " miss vmem"}, valid_to_mem, 1);
            check({nm, " miss addr"}, addr_to_mem, la);
            check({nm, " miss ready"}, ready_to_fetcher, 0);
            for (int i = 1; i < lat; i++) begin
                if (kill && i == 1) begin
                    flush = 1'b1;
                    valid_from_fetcher = 1'b0;
                end
                addr_from_fetcher = $urandom;
                step();
                flush = 1'b0;
                check({nm, " wait vmem"}, valid_to_mem, 1);
                check({nm, " wait ready"}, ready_to_fetcher, 0);
            end
            if (kill && lat == 1) begin
                flush = 1'b1;
                valid_from_fetcher = 1'b0;
            end
            ready_from_mem = 1'b1;
            data_from_mem = mem_line(la);
            step();
            ready_from_mem = 1'b0;
            flush = 1'b0;
            data_from_mem = {$urandom, $urandom, $urandom, $urandom};
            m_valid[la[9:4]] = 1'b1;
            m_tag[la[9:4]] = la[31:10];
            check({nm, " fill ready"}, ready_to_fetcher, kill ? 0 : 1);
            if (!kill) check({nm, " fill inst"}, inst_to_fetcher, mem_word(a));
            check({nm, " fill vmem"}, valid_to_mem, 0);
        end
        valid_from_fetcher = 1'b0;
        step();
        check({nm, " resp ready"}, ready_to_fetcher, 0);
        check({nm, " resp vmem"}, valid_to_mem, 0);
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[a[9:4]] && m_tag[a[9:4]] == a[31:10];
    endfunction

    initial begin
        vt[0] = '{32'h0000_0104, 3, 1'b0};
        vt[1] = '{32'h0000_0108, 1, 1'b1};
        vt[2] = '{32'h0000_0500, 2, 1'b0};
        vt[3] = '{32'h0000_0104, 1, 1'b0};
        vt[4] = '{32'h0000_0100, 1, 1'b1};
        vt[5] = '{32'h0000_010F, 1, 1'b1};

        step();
        step();
        check("reset ready", ready_to_fetcher, 0);
        check("reset vmem", valid_to_mem, 0);
        check("reset inst", inst_to_fetcher, 0);
        check("reset addr", addr_to_mem, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) fetch(vt[i].addr, vt[i].lat, 1'b0, vt[i].exp_hit, $sformatf("vec%0d", i));

        // Held request on a hit line: pulses on alternate cycles only.
        addr_from_fetcher = 32'h104;
        valid_from_fetcher = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("hold pulse%0d", i), ready_to_fetcher, (i % 2 == 0) ? 1 : 0);
            check($sformatf("hold vmem%0d", i), valid_to_mem, 0);
        end
        m_hits += 4;
        valid_from_fetcher = 1'b0;
        step();

        // Flush in IDLE blocks acceptance.
        addr_from_fetcher = 32'h104;
        valid_from_fetcher = 1'b1;
        flush = 1'b1;
        step();
        check("idle flush ready", ready_to_fetcher, 0);
        check("idle flush vmem", valid_to_mem, 0);
        flush = 1'b0;
        valid_from_fetcher = 1'b0;
        step();

        fetch(32'h2040, 3, 1'b1, 1'b0, "kill mid");
        fetch(32'h2044, 1, 1'b0, 1'b1, "after kill");
        fetch(32'h3080, 1, 1'b1, 1'b0, "kill same");
        fetch(32'h3088, 1, 1'b0, 1'b1, "after same");

        // Stall during a miss, then reset mid-miss.
        addr_from_fetcher = 32'h4000;
        valid_from_fetcher = 1'b1;
        step();
        m_misses++;
        check("stall vmem0", valid_to_mem, 1);
        rdy = 1'b0;
        addr_from_fetcher = 32'hFFFF_FFF0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall vmem%0d", i), valid_to_mem, 1);
            check($sformatf("stall addr%0d", i), addr_to_mem, 32'h4000);
            check($sformatf("stall ready%0d", i), ready_to_fetcher, 0);
        end
        rdy = 1'b1;
        step();
        check("unstall vmem", valid_to_mem, 1);
        check("unstall addr", addr_to_mem, 32'h4000);
        rst = 1'b1;
        step();
        check("rst mid vmem", valid_to_mem, 0);
        check("rst mid ready", ready_to_fetcher, 0);
        check("rst mid addr", addr_to_mem, 0);
        rst = 1'b0;
        valid_from_fetcher = 1'b0;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_misses = 0;
        step();
        fetch(32'h104, 2, 1'b0, 1'b0, "post rst");
        fetch(32'h2044, 1, 1'b0, 1'b0, "post rst2");

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 4) | ($urandom & 32'hF);
            fetch(a, $urandom_range(1, 4), $urandom_range(0, 7) == 0, model_hit(a), $sformatf("rnd%0d", n));
        end

`ifdef ICACHE_PERF_CNT_EN
        check("hit_cnt", hit_cnt, m_hits);
        check("miss_cnt", miss_cnt, m_misses);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
